// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: frame width,
// default bit period and the receiver state encoding.
package uart_pkg;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_CLKS_PER_BIT = 16;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_START = 3'd1;
   localparam state_t ST_DATA  = 3'd2;
   localparam state_t ST_STOP  = 3'd3;
   localparam state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte signals of the UART receiver.
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_if;
   import uart_pkg::*;

   logic                      rxd;
   logic [UART_DATA_BITS-1:0] rx_data;
   logic                      rx_valid;
   logic                      rx_frame_err;
   logic                      rx_busy;

   modport master (
      input  rxd,
      output rx_data,
      output rx_valid,
      output rx_frame_err,
      output rx_busy
   );

   modport slave (
      output rxd,
      input  rx_data,
      input  rx_valid,
      input  rx_frame_err,
      input  rx_busy
   );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input; the reset
// value is chosen so that the output matches the input's idle level.
module uart_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stage_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_reg <= {STAGES{RESET_VAL}};
      end else begin
         stage_reg <= {stage_reg[STAGES-2:0], d};
      end
   end

   assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation at mid-bit, LSB-first data capture,
// stop-bit check with framing-error reporting and break handling.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.master bus
);

   localparam int          HALF_BIT = (CLKS_PER_BIT - 1) / 2;
   localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);
   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic                      rxd_s;
   state_t                    state_reg,   state_next;
   logic [15:0]               clk_cnt_reg, clk_cnt_next;
   logic [2:0]                bit_idx_reg, bit_idx_next;
   logic [UART_DATA_BITS-1:0] shreg_reg,   shreg_next;
   logic [UART_DATA_BITS-1:0] data_reg,    data_next;
   logic                      valid_reg,   valid_next;
   logic                      err_reg,     err_next;

   // Reset to 1 so an idle line never looks like a start bit after reset.
   uart_sync #(
      .STAGES    (2),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.rxd),
      .q     (rxd_s)
   );

   always_comb begin
      state_next   = state_reg;
      clk_cnt_next = clk_cnt_reg;
      bit_idx_next = bit_idx_reg;
      shreg_next   = shreg_reg;
      data_next    = data_reg;
      valid_next   = 1'b0;
      err_next     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            clk_cnt_next = '0;
            if (!rxd_s) begin
               state_next = ST_START;
            end
         end

         ST_START: begin
            if (clk_cnt_reg == HALF_CNT) begin
               clk_cnt_next = '0;
               if (!rxd_s) begin
                  state_next   = ST_DATA;
                  bit_idx_next = '0;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               clk_cnt_next = clk_cnt_reg + 16'd1;
            end
         end

         // Counting is anchored to the centre of the start bit, so each
         // full-period wrap lands in the middle of the next bit.
         ST_DATA: begin
            if (clk_cnt_reg == LAST_CNT) begin
               clk_cnt_next = '0;
               shreg_next   = {rxd_s, shreg_reg[UART_DATA_BITS-1:1]};
               if (bit_idx_reg == LAST_BIT) begin
                  state_next = ST_STOP;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
               end
            end else begin
               clk_cnt_next = clk_cnt_reg + 16'd1;
            end
         end

         ST_STOP: begin
            if (clk_cnt_reg == LAST_CNT) begin
               clk_cnt_next = '0;
               if (rxd_s) begin
                  data_next  = shreg_reg;
                  valid_next = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  err_next   = 1'b1;
                  state_next = ST_BREAK;
               end
            end else begin
               clk_cnt_next = clk_cnt_reg + 16'd1;
            end
         end

         // Wait out a held-low line so a break reports only one error.
         ST_BREAK: begin
            clk_cnt_next = '0;
            if (rxd_s) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next   = ST_IDLE;
            clk_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         clk_cnt_reg <= '0;
         bit_idx_reg <= '0;
         shreg_reg   <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         clk_cnt_reg <= clk_cnt_next;
         bit_idx_reg <= bit_idx_next;
         shreg_reg   <= shreg_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         err_reg     <= err_next;
      end
   end

   assign bus.rx_data      = data_reg;
   assign bus.rx_valid     = valid_reg;
   assign bus.rx_frame_err = err_reg;
   assign bus.rx_busy      = (state_reg != ST_IDLE);

endmodule
